// File: rtl/product_bcd_pkg.sv
// product_bcd_pkg
// Shared defaults and state encoding for the signed-product to BCD converter.
//   WIDTH_DEF  : default signed product width (8x8 Booth multiplier output)
//   DIGITS_DEF : default BCD digit count, enough for a magnitude of 2^(WIDTH-1)
//   state_t    : converter sequencing states
package product_bcd_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int DIGITS_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/product_bcd_add3.sv
// bcd_add3
// Combinational double-dabble digit adjust: a digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next decade.
//   din  : 4-bit BCD digit before adjust
//   dout : 4-bit adjusted digit
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Digit correction ahead of the shift
    always_comb begin
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/product_bcd.sv
// product_bcd
// Converts a signed two's-complement product to sign + BCD magnitude using a
// sequential double-dabble, one bit per cycle, with fixed latency.
//   Clock    : system clock, rising edge
//   Reset    : synchronous active-high reset
//   iStart   : conversion request, honoured only when idle
//   iProduct : signed product, sampled only on the accepted start
//   oBusy    : high while converting (CONV and DONE states)
//   oDone    : one-cycle pulse when oSign/oBcd are updated
//   oSign    : 1 when the converted product was negative
//   oBcd     : BCD magnitude, least significant digit in [3:0]
module product_bcd
    import product_bcd_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [WIDTH-1:0]      iProduct,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oSign,
    output logic [4*DIGITS-1:0]   oBcd
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                state_r;
    logic                  sign_r;
    logic [WIDTH:0]        mag_r;
    logic [4*DIGITS-1:0]   scratch_r;
    logic [CNT_W-1:0]      cnt_r;

    logic [WIDTH:0]        ext_s;
    logic [WIDTH:0]        mag_in_s;
    logic [4*DIGITS-1:0]   adj_s;

    // Magnitude at WIDTH+1 bits so the most negative product negates exactly
    always_comb begin
        ext_s = {iProduct[WIDTH-1], iProduct};
        if (ext_s[WIDTH]) begin
            mag_in_s = ~ext_s + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            mag_in_s = ext_s;
        end
    end

    // One add-3 corrector per scratch digit
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .din  (scratch_r[4*g +: 4]),
            .dout (adj_s[4*g +: 4])
        );
    end

    // Sequencer: latch on start, WIDTH+1 adjust-and-shift steps, then publish
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            sign_r    <= 1'b0;
            mag_r     <= {(WIDTH+1){1'b0}};
            scratch_r <= {(4*DIGITS){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oSign     <= 1'b0;
            oBcd      <= {(4*DIGITS){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        sign_r    <= iProduct[WIDTH-1];
                        mag_r     <= mag_in_s;
                        scratch_r <= {(4*DIGITS){1'b0}};
                        cnt_r     <= {CNT_W{1'b0}};
                        oBusy     <= 1'b1;
                        state_r   <= ST_CONV;
                    end else begin
                        oBusy     <= 1'b0;
                    end
                end
                ST_CONV: begin
                    // The magnitude MSB shifts into the adjusted scratch LSB
                    scratch_r <= {adj_s[4*DIGITS-2:0], mag_r[WIDTH]};
                    mag_r     <= {mag_r[WIDTH-1:0], 1'b0};
                    oBusy     <= 1'b1;
                    oDone     <= 1'b0;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    oBcd    <= scratch_r;
                    oSign   <= sign_r;
                    oDone   <= 1'b1;
                    oBusy   <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    oBusy   <= 1'b0;
                    oDone   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd.sv
// tb_product_bcd
// Scoreboard bench: the driver pushes the hand-computed result and the cycle
// at which oDone must appear; a monitor pops and compares on every oDone.
module tb_product_bcd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] prod;
    logic        busy;
    logic        done;
    logic        sign;
    logic [19:0] bcd;

    typedef struct {
        logic        s;
        logic [19:0] b;
        int unsigned c;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          done_count = 0;

    product_bcd #(.WIDTH(16), .DIGITS(5)) dut (
        .Clock    (clk),
        .Reset    (rst),
        .iStart   (start),
        .iProduct (prod),
        .oBusy    (busy),
        .oDone    (done),
        .oSign    (sign),
        .oBcd     (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every oDone must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got oDone=1 at cycle %0d expected no pulse", cyc);
            end else begin
                e = sb.pop_front();
                check("sign", {31'd0, sign}, {31'd0, e.s});
                check("bcd", {12'd0, bcd}, {12'd0, e.b});
                check("done_cycle", cyc, e.c);
            end
        end
    end

    // Issue one start pulse; the expectation is due 18 edges after acceptance
    task automatic start_conv(input logic [15:0] p, input logic es, input logic [19:0] eb,
                              input bit expect_done);
        exp_t e;
        @(negedge clk);
        prod  = p;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (expect_done) begin
            e.s = es;
            e.b = eb;
            e.c = cyc + 18;
            sb.push_back(e);
        end
        @(negedge clk);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        start = 1'b0;
        prod  = 16'hDEAD;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        int unsigned k;
        int          dc;
        exp_t        e;
        rst   = 1'b1;
        start = 1'b0;
        prod  = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sign", {31'd0, sign}, 32'd0);
        check("rst_bcd", {12'd0, bcd}, 32'd0);
        rst = 1'b0;

        // Directed values: -128*-128, -128*127 (with hold check), extremes
        start_conv(16'h4000, 1'b0, 20'h16384, 1'b1);
        wait_idle();
        start_conv(16'hC080, 1'b1, 20'h16256, 1'b1);
        repeat (4) @(negedge clk);
        check("hold_bcd", {12'd0, bcd}, 32'h16384);
        check("hold_sign", {31'd0, sign}, 32'd0);
        wait_idle();
        start_conv(16'h8000, 1'b1, 20'h32768, 1'b1);
        wait_idle();
        start_conv(16'h0000, 1'b0, 20'h00000, 1'b1);
        wait_idle();

        // A start pulse mid-conversion must be ignored
        dc = done_count;
        start_conv(16'h0063, 1'b0, 20'h00099, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        prod  = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (25) @(negedge clk);
        check("single_done", done_count, dc + 1);

        // Held start: back-to-back conversions every 19 cycles
        @(negedge clk);
        prod  = 16'hFF38;
        start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        for (int i = 0; i < 3; i++) begin
            e.s = 1'b1;
            e.b = 20'h00200;
            e.c = k + 18 + 19 * i;
            sb.push_back(e);
        end
        do @(negedge clk); while (cyc < k + 38);
        start = 1'b0;
        wait_idle();

        // Reset five cycles into a conversion aborts it silently
        start_conv(16'h1234, 1'b0, 20'h04660, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_bcd", {12'd0, bcd}, 32'd0);
        check("abort_sign", {31'd0, sign}, 32'd0);
        rst = 1'b0;
        dc = done_count;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_count, dc);

        // Reset beats a simultaneous start
        prod  = 16'h0063;
        start = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check("rst_wins_busy", {31'd0, busy}, 32'd0);
        dc = done_count;
        repeat (25) @(negedge clk);
        check("rst_wins_no_done", done_count, dc);

        // Normal operation resumes afterwards: 127*127
        start_conv(16'h3F01, 1'b0, 20'h16129, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
